// File: rtl/dmem_arb_pkg.sv
//==============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package dmem_arb_pkg;

    // Arbiter ownership: core-priority arbitration or a locked host burst
    typedef enum logic [0:0] {
        ST_CORE = 1'b0,
        ST_HOST = 1'b1
    } arb_state_t;

    // Port-mux select encoding
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    // Width of the core/host word address buses
    localparam int c_cpu_addr_w = 16;

    // Counter width needed to hold the value 'limit'
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_sat_counter.sv
//==============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that sticks at LIMIT.
//            Clear has priority over increment.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_sat
);

    localparam logic [WIDTH-1:0] c_limit = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    // Count up on request, hold at the limit, clear on demand
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_limit)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_sat   = (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the single-port data memory between the core load/store
//            port and a host port. Core has priority; the host is protected
//            by an anti-starvation counter and may lock bounded bursts.
//            Grants are combinational, so no latency is added to the access.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int P_WORD_LEN     = 16,
    parameter int P_ADDR_LEN     = 10,
    parameter int P_STARVE_LIMIT = 4,
    parameter int P_MAX_BURST    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    // core load/store port
    input  logic                    i_core_req,
    input  logic                    i_core_wr_en,
    input  logic [c_cpu_addr_w-1:0] i_core_addr,
    input  logic [P_WORD_LEN-1:0]   i_core_wr_data,
    output logic [P_WORD_LEN-1:0]   o_core_rd_data,
    output logic                    o_core_stall,
    // host port
    input  logic                    i_host_req,
    input  logic                    i_host_wr_en,
    input  logic                    i_host_lock,
    input  logic [c_cpu_addr_w-1:0] i_host_addr,
    input  logic [P_WORD_LEN-1:0]   i_host_wr_data,
    output logic                    o_host_gnt,
    output logic [P_WORD_LEN-1:0]   o_host_rd_data,
    // memory port
    output logic [P_ADDR_LEN-1:0]   o_mem_addr,
    output logic [P_WORD_LEN-1:0]   o_mem_wr_data,
    output logic                    o_mem_wr_en,
    input  logic [P_WORD_LEN-1:0]   i_mem_rd_data
);

    localparam int c_starve_w = cnt_width(P_STARVE_LIMIT);
    localparam int c_burst_w  = cnt_width(P_MAX_BURST);

    // Burst counter value before the beat that completes a maximal burst
    localparam logic [c_burst_w-1:0] c_burst_last = c_burst_w'(P_MAX_BURST - 1);

    // A one-beat burst limit means a lock never leaves core arbitration
    localparam bit c_burst_enable = (P_MAX_BURST > 1);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic                    w_core_gnt;
    logic                    w_host_gnt;
    logic                    w_any_gnt;
    logic                    w_burst_exit;

    logic [c_starve_w-1:0]   w_starve_cnt;
    logic                    w_starve_sat;
    logic                    w_starve_inc;
    logic                    w_starve_clr;

    logic [c_burst_w-1:0]    w_burst_cnt;
    logic                    w_burst_sat;
    logic                    w_burst_inc;
    logic                    w_burst_clr;

    logic                    w_sel;
    logic                    w_sel_wr;
    logic [c_cpu_addr_w-1:0] w_sel_addr;
    logic [P_WORD_LEN-1:0]   w_sel_wdata;
    logic                    w_mapped;

    // Starvation state only matters once saturated; the raw count is kept
    // for visibility in waveforms.
    logic w_unused;
    assign w_unused = ^w_starve_cnt;

    // Consecutive cycles a requesting host has been refused
    sat_counter #(
        .WIDTH (c_starve_w),
        .LIMIT (P_STARVE_LIMIT)
    ) u_starve_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_starve_inc),
        .i_clr   (w_starve_clr),
        .o_count (w_starve_cnt),
        .o_sat   (w_starve_sat)
    );

    // Beats performed in the current locked host burst
    sat_counter #(
        .WIDTH (c_burst_w),
        .LIMIT (P_MAX_BURST)
    ) u_burst_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_burst_inc),
        .i_clr   (w_burst_clr),
        .o_count (w_burst_cnt),
        .o_sat   (w_burst_sat)
    );

    // Ownership state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CORE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decision, burst tracking and next ownership state
    always_comb begin
        w_state_nxt  = r_state;
        w_core_gnt   = 1'b0;
        w_host_gnt   = 1'b0;
        w_burst_inc  = 1'b0;
        w_burst_clr  = 1'b0;
        w_burst_exit = 1'b0;
        unique case (r_state)
            ST_CORE: begin
                // Core wins unless a waiting host has hit its starvation bound
                w_core_gnt = i_core_req && !(i_host_req && w_starve_sat);
                w_host_gnt = i_host_req && !w_core_gnt;
                if (c_burst_enable && w_host_gnt && i_host_lock) begin
                    // This beat is the first of the burst
                    w_state_nxt = ST_HOST;
                    w_burst_inc = 1'b1;
                end else begin
                    w_burst_clr = 1'b1;
                end
            end
            ST_HOST: begin
                w_host_gnt  = i_host_req;
                w_burst_inc = i_host_req;
                if (!i_host_req || !i_host_lock ||
                    (w_burst_cnt == c_burst_last) || w_burst_sat) begin
                    w_state_nxt  = ST_CORE;
                    w_burst_clr  = 1'b1;
                    w_burst_exit = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_CORE;
                w_burst_clr = 1'b1;
            end
        endcase
    end

    // A refused host ages; any grant, withdrawal or burst end restarts it
    assign w_starve_inc = i_host_req && !w_host_gnt;
    assign w_starve_clr = !i_host_req || w_host_gnt || w_burst_exit;

    assign w_any_gnt = w_core_gnt || w_host_gnt;

    // Route the granted requester onto the memory port (core by default)
    always_comb begin
        w_sel       = w_host_gnt ? PORT_HOST : PORT_CORE;
        w_sel_wr    = i_core_wr_en;
        w_sel_addr  = i_core_addr;
        w_sel_wdata = i_core_wr_data;
        if (w_sel == PORT_HOST) begin
            w_sel_wr    = i_host_wr_en;
            w_sel_addr  = i_host_addr;
            w_sel_wdata = i_host_wr_data;
        end
    end

    // Words above the implemented range are unmapped: no write, reads as 0
    assign w_mapped = ((w_sel_addr >> P_ADDR_LEN) == '0);

    assign o_mem_addr     = w_any_gnt ? w_sel_addr[P_ADDR_LEN-1:0] : '0;
    assign o_mem_wr_data  = w_any_gnt ? w_sel_wdata : '0;
    assign o_mem_wr_en    = w_any_gnt && w_sel_wr && w_mapped;

    assign o_core_rd_data = (w_core_gnt && w_mapped) ? i_mem_rd_data : '0;
    assign o_host_rd_data = (w_host_gnt && w_mapped) ? i_mem_rd_data : '0;

    assign o_core_stall   = i_core_req && !w_core_gnt;
    assign o_host_gnt     = w_host_gnt;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//==============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a behavioural memory,
//            a shadow copy of expected memory contents and a read scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_wr_en;
    logic [15:0] core_addr, core_wr_data, core_rd_data;
    logic        core_stall;
    logic        host_req, host_wr_en, host_lock;
    logic [15:0] host_addr, host_wr_data, host_rd_data;
    logic        host_gnt;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wr_data, mem_rd_data;
    logic        mem_wr_en;

    logic [15:0] mem    [0:1023];
    logic [15:0] shadow [0:1023];

    typedef struct {
        logic        is_host;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(
        .P_WORD_LEN     (16),
        .P_ADDR_LEN     (10),
        .P_STARVE_LIMIT (4),
        .P_MAX_BURST    (8)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_core_req     (core_req),
        .i_core_wr_en   (core_wr_en),
        .i_core_addr    (core_addr),
        .i_core_wr_data (core_wr_data),
        .o_core_rd_data (core_rd_data),
        .o_core_stall   (core_stall),
        .i_host_req     (host_req),
        .i_host_wr_en   (host_wr_en),
        .i_host_lock    (host_lock),
        .i_host_addr    (host_addr),
        .i_host_wr_data (host_wr_data),
        .o_host_gnt     (host_gnt),
        .o_host_rd_data (host_rd_data),
        .o_mem_addr     (mem_addr),
        .o_mem_wr_data  (mem_wr_data),
        .o_mem_wr_en    (mem_wr_en),
        .i_mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on rising edge
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    assign mem_rd_data = mem[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        core_req = 0; core_wr_en = 0; core_addr = 0; core_wr_data = 0;
        host_req = 0; host_wr_en = 0; host_lock = 0; host_addr = 0; host_wr_data = 0;
    endtask

    // Queue the value a read of 'addr' must return
    task automatic push_read(input logic is_host, input logic [15:0] addr);
        exp_t e;
        e.is_host = is_host;
        e.addr    = addr;
        e.data    = ((addr >> 10) != 0) ? 16'h0000 : shadow[addr[9:0]];
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({core_stall, host_gnt, mem_wr_en, mem_addr, mem_wr_data, core_rd_data, host_rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_assert: outputs %b, expected all 0",
                     {core_stall, host_gnt, mem_wr_en, mem_addr, mem_wr_data, core_rd_data, host_rd_data});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({core_stall, host_gnt, mem_wr_en, mem_addr, mem_wr_data, core_rd_data, host_rd_data} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs %b, expected all 0", i,
                         {core_stall, host_gnt, mem_wr_en, mem_addr, mem_wr_data, core_rd_data, host_rd_data});
            end
            tick();
        end
    endtask

    task automatic test_core_rw();
        exp_t e;
        // store
        drive_idle();
        core_req = 1; core_wr_en = 1; core_addr = 16'h0010; core_wr_data = 16'hBEEF;
        @(negedge clk);
        n_checks++;
        if ({core_stall, mem_wr_en, mem_addr, mem_wr_data} !== {1'b0, 1'b1, 10'h010, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL core_sw: stall/wr_en/addr/data = %b/%b/%h/%h, expected 0/1/010/beef",
                     core_stall, mem_wr_en, mem_addr, mem_wr_data);
        end
        shadow[10'h010] = 16'hBEEF;
        tick();
        // load
        core_wr_en = 0; core_wr_data = 0;
        push_read(1'b0, 16'h0010);
        @(negedge clk);
        n_checks++;
        if (core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL core_lw_stall: got %b expected 0", core_stall);
        end
        if (core_req && !core_stall) begin
            n_checks++;
            if (sb_q.size() == 0 || sb_q[0].is_host) begin
                n_fail++;
                $display("FAIL core_lw_sb: unexpected core read data %h", core_rd_data);
            end else begin
                e = sb_q.pop_front();
                if (core_rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL core_lw_data addr %h: got %h expected %h", e.addr, core_rd_data, e.data);
                end
            end
        end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_starvation();
        exp_t e;
        drive_idle();
        core_req = 1; core_addr = 16'h0020;
        host_req = 1; host_addr = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_read(1'b0, 16'h0020);
            else       push_read(1'b1, 16'h0010);
            @(negedge clk);
            n_checks++;
            if (host_gnt !== (i == 4) || core_stall !== (i == 4)) begin
                n_fail++;
                $display("FAIL starve_gnt cycle %0d: host_gnt/stall = %b/%b, expected %b/%b",
                         i, host_gnt, core_stall, (i == 4), (i == 4));
            end
            if ((core_req && !core_stall) || host_gnt) begin
                n_checks++;
                if (sb_q.size() == 0 || sb_q[0].is_host !== host_gnt) begin
                    n_fail++;
                    $display("FAIL starve_sb cycle %0d: unexpected grant host=%b", i, host_gnt);
                end else begin
                    e = sb_q.pop_front();
                    if ((host_gnt ? host_rd_data : core_rd_data) !== e.data) begin
                        n_fail++;
                        $display("FAIL starve_rd cycle %0d: got %h expected %h", i,
                                 host_gnt ? host_rd_data : core_rd_data, e.data);
                    end
                end
            end
            tick();
        end
        drive_idle();
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL starve_pending: %0d reads never granted, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_burst_idle();
        exp_t e;
        int k = 0;
        drive_idle();
        for (int c = 0; c < 10; c++) begin
            host_req = 1; host_lock = 1; host_wr_en = 1;
            host_addr = 16'h0100 + 16'(k); host_wr_data = 16'hA000 + 16'(k);
            @(negedge clk);
            n_checks++;
            if (host_gnt !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 10'(16'h0100 + 16'(k))) begin
                n_fail++;
                $display("FAIL burst_idle_beat cycle %0d: gnt/wr_en/addr = %b/%b/%h, expected 1/1/%h",
                         c, host_gnt, mem_wr_en, mem_addr, 10'(16'h0100 + 16'(k)));
            end
            if (host_gnt) begin
                shadow[10'(16'h0100 + 16'(k))] = 16'hA000 + 16'(k);
                k++;
            end
            tick();
        end
        drive_idle();
        tick();
        // read the burst back through the core port
        for (int a = 0; a < 10; a++) begin
            core_req = 1; core_addr = 16'h0100 + 16'(a);
            push_read(1'b0, core_addr);
            @(negedge clk);
            n_checks++;
            if (core_stall || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL burst_readback_gnt addr %h: stall %b, expected 0", core_addr, core_stall);
            end else begin
                e = sb_q.pop_front();
                if (core_rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL burst_readback addr %h: got %h expected %h", e.addr, core_rd_data, e.data);
                end
            end
            tick();
        end
        drive_idle();
        tick();
        sb_q.delete();
    endtask

    task automatic test_burst_contended();
        exp_t e;
        int k = 0;
        logic exp_gnt [18] = '{0,0,0,0, 1,1,1,1,1,1,1,1, 0,0,0,0, 1,1};
        drive_idle();
        for (int c = 0; c < 18; c++) begin
            core_req = 1; core_addr = 16'h0020;
            host_req = (k < 10); host_lock = 1; host_wr_en = 1;
            host_addr = 16'h0200 + 16'(k); host_wr_data = 16'h5000 + 16'(k);
            if (!exp_gnt[c]) push_read(1'b0, 16'h0020);
            @(negedge clk);
            n_checks++;
            if (host_gnt !== exp_gnt[c] || core_stall !== exp_gnt[c]) begin
                n_fail++;
                $display("FAIL burst_cont cycle %0d: host_gnt/stall = %b/%b, expected %b/%b",
                         c, host_gnt, core_stall, exp_gnt[c], exp_gnt[c]);
            end
            if (core_req && !core_stall) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL burst_cont_sb cycle %0d: core granted, expected stall", c);
                end else begin
                    e = sb_q.pop_front();
                    if (core_rd_data !== e.data) begin
                        n_fail++;
                        $display("FAIL burst_cont_rd cycle %0d: got %h expected %h", c, core_rd_data, e.data);
                    end
                end
            end
            if (host_gnt) begin
                shadow[10'(16'h0200 + 16'(k))] = 16'h5000 + 16'(k);
                k++;
            end
            tick();
        end
        drive_idle();
        tick();
        n_checks++;
        if (k != 10 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL burst_cont_done: beats %0d pending %0d, expected 10 and 0", k, sb_q.size());
            sb_q.delete();
        end
        for (int a = 0; a < 10; a++) begin
            n_checks++;
            if (mem[10'h200 + 10'(a)] !== shadow[10'h200 + 10'(a)]) begin
                n_fail++;
                $display("FAIL burst_cont_mem addr %h: got %h expected %h",
                         10'h200 + 10'(a), mem[10'h200 + 10'(a)], shadow[10'h200 + 10'(a)]);
            end
        end
    endtask

    task automatic test_unmapped();
        exp_t e;
        logic [15:0] addrs [2] = '{16'h0400, 16'h0000};
        drive_idle();
        core_req = 1; core_wr_en = 1; core_addr = 16'h0400; core_wr_data = 16'h1234;
        @(negedge clk);
        n_checks++;
        if (mem_wr_en !== 1'b0 || core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL unmapped_sw: wr_en/stall = %b/%b, expected 0/0", mem_wr_en, core_stall);
        end
        tick();
        core_wr_en = 0; core_wr_data = 0;
        for (int i = 0; i < 2; i++) begin
            core_addr = addrs[i];
            push_read(1'b0, core_addr);
            @(negedge clk);
            n_checks++;
            if (core_stall || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unmapped_lw_gnt addr %h: stall %b, expected 0", core_addr, core_stall);
            end else begin
                e = sb_q.pop_front();
                if (core_rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL unmapped_lw addr %h: got %h expected %h", e.addr, core_rd_data, e.data);
                end
            end
            tick();
        end
        drive_idle();
        tick();
        sb_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int k = 0;
        logic exp_gnt [6] = '{0,0,0,0,1,1};
        drive_idle();
        for (int c = 0; c < 6; c++) begin
            core_req = 1; core_addr = 16'h0010;
            host_req = 1; host_lock = 1; host_wr_en = 1;
            host_addr = 16'h0300 + 16'(k); host_wr_data = 16'h7000 + 16'(k);
            @(negedge clk);
            n_checks++;
            if (host_gnt !== exp_gnt[c]) begin
                n_fail++;
                $display("FAIL rst_burst_lead cycle %0d: host_gnt %b expected %b", c, host_gnt, exp_gnt[c]);
            end
            if (host_gnt) begin
                shadow[10'(16'h0300 + 16'(k))] = 16'h7000 + 16'(k);
                k++;
            end
            tick();
        end
        // third beat is on the bus
        host_addr = 16'h0300 + 16'(k); host_wr_data = 16'h7000 + 16'(k);
        #1;
        n_checks++;
        if (host_gnt !== 1'b1 || core_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_burst_beat3: host_gnt/stall = %b/%b, expected 1/1", host_gnt, core_stall);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (host_gnt !== 1'b0 || core_stall !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_burst_async: host_gnt/stall/wr_en = %b/%b/%b, expected 0/0/0",
                     host_gnt, core_stall, mem_wr_en);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (core_stall !== 1'b0 || host_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_burst_release: stall/host_gnt = %b/%b, expected 0/0", core_stall, host_gnt);
        end
        tick();
        drive_idle();
        tick();
        for (int a = 0; a < 3; a++) begin
            n_checks++;
            if (mem[10'h300 + 10'(a)] !== shadow[10'h300 + 10'(a)]) begin
                n_fail++;
                $display("FAIL rst_burst_mem addr %h: got %h expected %h",
                         10'h300 + 10'(a), mem[10'h300 + 10'(a)], shadow[10'h300 + 10'(a)]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 16'h0000;
            shadow[i] = 16'h0000;
        end
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_core_rw();
        test_starvation();
        test_burst_idle();
        test_burst_contended();
        test_unmapped();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
